// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : Architectural register file (x0-x31) with per-register rename
//             tags for the out-of-order core. Serves two combinational source
//             lookups for the decoder, accepts rename writes from dispatch,
//             retires commits from the ROB and drops all rename state on
//             a mispredict flush.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             rdy               - global enable, all state holds when low
//             flush             - mispredict flush, clears every tag
//             stall             - dispatch stall, blocks rename
//             dec_ready         - decoder presents a valid instruction
//             dec_rs1/dec_rs2   - source register indices
//             dec_rd            - destination index (0 = no destination)
//             rob_tail_id       - ROB id given to the dispatching instruction
//             rob_head_id       - current ROB head
//             rob_rf_enable/rd/val - commit write from the ROB
//             rf_dep1/rf_dep2   - source tags (all-ones = value is in the RF)
//             rf_val1/rf_val2   - source values
//  Revision : 1.0 - initial release
// ============================================================================
module register_file #(
   parameter int XLEN             = 32,
   parameter int REG_CNT_WIDTH    = 5,
   parameter int ROB_SIZE_WIDTH   = 3,
   parameter int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rdy,
   input  logic                        flush,
   input  logic                        stall,
   input  logic                        dec_ready,
   input  logic [REG_CNT_WIDTH-1:0]    dec_rs1,
   input  logic [REG_CNT_WIDTH-1:0]    dec_rs2,
   input  logic [REG_CNT_WIDTH-1:0]    dec_rd,
   input  logic [ROB_SIZE_WIDTH-1:0]   rob_tail_id,
   input  logic [ROB_SIZE_WIDTH-1:0]   rob_head_id,
   input  logic                        rob_rf_enable,
   input  logic [REG_CNT_WIDTH-1:0]    rob_rf_rd,
   input  logic [XLEN-1:0]             rob_rf_val,
   output logic [DEPENDENCY_WIDTH-1:0] rf_dep1,
   output logic [DEPENDENCY_WIDTH-1:0] rf_dep2,
   output logic [XLEN-1:0]             rf_val1,
   output logic [XLEN-1:0]             rf_val2
);

   localparam int REG_CNT = 1 << REG_CNT_WIDTH;
   localparam logic [DEPENDENCY_WIDTH-1:0] C_NO_DEP = '1;

   logic [XLEN-1:0]             r_regs [REG_CNT];
   logic [DEPENDENCY_WIDTH-1:0] r_dep  [REG_CNT];

   // The ROB advances its head on the same edge that registers the commit
   // port, so the committing entry is the one just behind the head.
   logic [ROB_SIZE_WIDTH-1:0]   w_commit_id;
   logic [DEPENDENCY_WIDTH-1:0] w_commit_tag;
   logic                        w_commit_en;
   logic                        w_rename_en;

   assign w_commit_id  = rob_head_id - ROB_SIZE_WIDTH'(1);
   assign w_commit_tag = {1'b0, w_commit_id};
   assign w_commit_en  = rob_rf_enable && (rob_rf_rd != '0);
   assign w_rename_en  = dec_ready && !stall && !flush && (dec_rd != '0);

   // -------------------------------------------------------------------------
   // State update
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_CNT; i++) begin
            r_regs[i] <= '0;
            r_dep[i]  <= C_NO_DEP;
         end
      end else if (rdy) begin
         for (int i = 0; i < REG_CNT; i++) begin
            // Value write happens even under flush (JALR commits and flushes
            // together).
            if (w_commit_en && (rob_rf_rd == REG_CNT_WIDTH'(i))) begin
               r_regs[i] <= rob_rf_val;
            end

            if (flush) begin
               r_dep[i] <= C_NO_DEP;
            end else if (w_rename_en && (dec_rd == REG_CNT_WIDTH'(i))) begin
               // A new rename beats a same-cycle commit to the same register.
               r_dep[i] <= {1'b0, rob_tail_id};
            end else if (w_commit_en && (rob_rf_rd == REG_CNT_WIDTH'(i)) &&
                         (r_dep[i] == w_commit_tag)) begin
               // Only clear the tag if this commit is its latest producer;
               // a younger rename must keep waiting.
               r_dep[i] <= C_NO_DEP;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read ports: x0 is hardwired, a matching commit is bypassed, otherwise
   // the stored tag/value is returned. A rename being dispatched this cycle
   // is not visible, so rs == rd in one instruction sees the older tag.
   // -------------------------------------------------------------------------
   for (genvar k = 0; k < 2; k++) begin : g_read_port
      logic [REG_CNT_WIDTH-1:0]    w_rs;
      logic [DEPENDENCY_WIDTH-1:0] w_dep;
      logic [XLEN-1:0]             w_val;

      assign w_rs = (k == 0) ? dec_rs1 : dec_rs2;

      always_comb begin
         w_dep = r_dep[w_rs];
         w_val = r_regs[w_rs];
         if (w_rs == '0) begin
            w_dep = C_NO_DEP;
            w_val = '0;
         end else if (rob_rf_enable && (rob_rf_rd == w_rs) &&
                      (r_dep[w_rs] == w_commit_tag)) begin
            w_dep = C_NO_DEP;
            w_val = rob_rf_val;
         end
      end
   end

   assign rf_dep1 = g_read_port[0].w_dep;
   assign rf_val1 = g_read_port[0].w_val;
   assign rf_dep2 = g_read_port[1].w_dep;
   assign rf_val2 = g_read_port[1].w_val;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file
//  Purpose  : Self-checking bench for register_file. Directed scenarios with
//             constant expectations, followed by random traffic compared to
//             a behavioural model of the register file.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

   localparam int XLEN     = 32;
   localparam int RW       = 5;
   localparam int RSW      = 3;
   localparam int DW       = RSW + 1;
   localparam int ROB_SIZE = 1 << RSW;
   localparam logic [DW-1:0] NODEP = '1;

   logic            clk = 1'b0;
   logic            rst, rdy, flush, stall, dec_ready;
   logic [RW-1:0]   dec_rs1, dec_rs2, dec_rd;
   logic [RSW-1:0]  rob_tail_id, rob_head_id;
   logic            rob_rf_enable;
   logic [RW-1:0]   rob_rf_rd;
   logic [XLEN-1:0] rob_rf_val;
   logic [DW-1:0]   rf_dep1, rf_dep2;
   logic [XLEN-1:0] rf_val1, rf_val2;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Model: tag -1 means "value is in the register file".
   int          m_dep  [32];
   logic [31:0] m_regs [32];

   always #5 clk = ~clk;

   register_file #(
      .XLEN(XLEN), .REG_CNT_WIDTH(RW), .ROB_SIZE_WIDTH(RSW), .DEPENDENCY_WIDTH(DW)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall(stall),
      .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_rd(dec_rd), .rob_tail_id(rob_tail_id), .rob_head_id(rob_head_id),
      .rob_rf_enable(rob_rf_enable), .rob_rf_rd(rob_rf_rd),
      .rob_rf_val(rob_rf_val), .rf_dep1(rf_dep1), .rf_dep2(rf_dep2),
      .rf_val1(rf_val1), .rf_val2(rf_val2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] tag_bits(input int t);
      return (t < 0) ? NODEP : DW'(t);
   endfunction

   function automatic int commit_id();
      return (int'(rob_head_id) + ROB_SIZE - 1) % ROB_SIZE;
   endfunction

   task automatic model_read(input int rs, output int t, output logic [31:0] v);
      if (rs == 0) begin
         t = -1; v = 0;
      end else if (rob_rf_enable && int'(rob_rf_rd) == rs && m_dep[rs] == commit_id()) begin
         t = -1; v = rob_rf_val;
      end else begin
         t = m_dep[rs]; v = m_regs[rs];
      end
   endtask

   task automatic model_edge();
      bit clr;
      int crd;
      clr = 0;
      crd = int'(rob_rf_rd);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_dep[i] = -1; end
      end else if (rdy) begin
         if (rob_rf_enable && crd != 0) begin
            clr = (m_dep[crd] == commit_id());
            m_regs[crd] = rob_rf_val;
         end
         if (flush) begin
            for (int i = 0; i < 32; i++) m_dep[i] = -1;
         end else begin
            if (clr) m_dep[crd] = -1;
            if (dec_ready && !stall && dec_rd != 0) m_dep[dec_rd] = int'(rob_tail_id);
         end
      end
   endtask

   // One clock: compare both read ports with the model, then advance.
   task automatic cycle(input string tag, input bit chk);
      int t;
      logic [31:0] v;
      #1;
      if (chk) begin
         model_read(int'(dec_rs1), t, v);
         check({tag, ".dep1"}, 64'(rf_dep1), 64'(tag_bits(t)));
         check({tag, ".val1"}, 64'(rf_val1), 64'(v));
         model_read(int'(dec_rs2), t, v);
         check({tag, ".dep2"}, 64'(rf_dep2), 64'(tag_bits(t)));
         check({tag, ".val2"}, 64'(rf_val2), 64'(v));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Constant-expectation read of one register through port 1.
   task automatic expect_read(input string tag, input logic [RW-1:0] rs,
                              input logic [DW-1:0] edep, input logic [31:0] eval);
      dec_rs1 = rs;
      #1;
      check({tag, ".dep"}, 64'(rf_dep1), 64'(edep));
      check({tag, ".val"}, 64'(rf_val1), 64'(eval));
   endtask

   task automatic idle();
      rst = 0; rdy = 1; flush = 0; stall = 0; dec_ready = 0;
      rob_rf_enable = 0; dec_rd = 0; rob_rf_rd = 0; rob_rf_val = 0;
   endtask

   task automatic rename(input logic [RW-1:0] rd, input logic [RSW-1:0] tail);
      idle();
      dec_ready = 1; dec_rd = rd; rob_tail_id = tail;
      cycle("rename", 1);
      idle();
   endtask

   initial begin
      idle();
      dec_rs1 = 0; dec_rs2 = 0; rob_tail_id = 0; rob_head_id = 0;
      for (int i = 0; i < 32; i++) begin m_regs[i] = 'x; m_dep[i] = -2; end

      // Reset
      @(negedge clk);
      rst = 1;
      cycle("reset", 0);
      idle();
      dec_rs2 = 0;
      expect_read("reset_rs5", 5, NODEP, 0);
      check("reset_rs0.dep", 64'(rf_dep2), 64'(NODEP));
      check("reset_rs0.val", 64'(rf_val2), 64'(0));
      cycle("post_reset", 1);

      // Rename then commit with bypass
      rename(3, 4);
      expect_read("rename_x3", 3, 4, 0);
      cycle("rename_read", 1);
      rob_rf_enable = 1; rob_rf_rd = 3; rob_rf_val = 32'hDEADBEEF; rob_head_id = 5;
      expect_read("bypass_x3", 3, NODEP, 32'hDEADBEEF);
      cycle("bypass", 1);
      idle();
      expect_read("after_commit_x3", 3, NODEP, 32'hDEADBEEF);
      cycle("after_commit", 1);

      // Stale commit keeps younger tag
      rename(7, 2);
      rename(7, 6);
      rob_rf_enable = 1; rob_rf_rd = 7; rob_rf_val = 32'h11; rob_head_id = 3;
      expect_read("stale_nobypass_x7", 7, 6, 0);
      cycle("stale_commit", 1);
      idle();
      expect_read("stale_x7", 7, 6, 32'h11);
      cycle("stale_after", 1);

      // Same-cycle rename and commit to the same register
      rename(9, 1);
      rob_rf_enable = 1; rob_rf_rd = 9; rob_rf_val = 32'h99; rob_head_id = 2;
      dec_ready = 1; dec_rd = 9; rob_tail_id = 7; dec_rs2 = 9;
      cycle("same_cycle", 1);
      idle();
      expect_read("same_cycle_x9", 9, 7, 32'h99);
      cycle("same_cycle_after", 1);

      // Flush with commit and concurrent rename
      rename(1, 0);
      rename(2, 1);
      rename(31, 2);
      flush = 1; rob_rf_enable = 1; rob_rf_rd = 1; rob_rf_val = 32'h80; rob_head_id = 3;
      dec_ready = 1; dec_rd = 4; rob_tail_id = 5;
      cycle("flush", 1);
      idle();
      expect_read("flush_x1", 1, NODEP, 32'h80);
      expect_read("flush_x2", 2, NODEP, 0);
      expect_read("flush_x31", 31, NODEP, 0);
      expect_read("flush_x4", 4, NODEP, 0);
      cycle("flush_after", 1);

      // Wrap-around commit id
      rename(12, 3'(ROB_SIZE - 1));
      rob_rf_enable = 1; rob_rf_rd = 12; rob_rf_val = 32'h55; rob_head_id = 0;
      cycle("wrap_commit", 1);
      idle();
      expect_read("wrap_x12", 12, NODEP, 32'h55);
      cycle("wrap_after", 1);

      // x0 is never renamed or written
      dec_ready = 1; dec_rd = 0; rob_tail_id = 3;
      rob_rf_enable = 1; rob_rf_rd = 0; rob_rf_val = 32'hFFFF;
      cycle("x0_write", 1);
      idle();
      expect_read("x0", 0, NODEP, 0);
      cycle("x0_after", 1);

      // rdy low holds everything; stall blocks rename
      rdy = 0; dec_ready = 1; dec_rd = 5; rob_tail_id = 1;
      rob_rf_enable = 1; rob_rf_rd = 3; rob_rf_val = 32'h1234; rob_head_id = 1;
      cycle("rdy_low", 1);
      idle();
      expect_read("rdy_low_x5", 5, NODEP, 0);
      expect_read("rdy_low_x3", 3, NODEP, 32'hDEADBEEF);
      stall = 1; dec_ready = 1; dec_rd = 6; rob_tail_id = 2;
      cycle("stall", 1);
      idle();
      expect_read("stall_x6", 6, NODEP, 0);
      cycle("stall_after", 1);

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         int rd;
         rst           = ($urandom_range(0, 99) == 0);
         rdy           = ($urandom_range(0, 9) != 0);
         flush         = ($urandom_range(0, 19) == 0);
         stall         = ($urandom_range(0, 5) == 0);
         dec_ready     = $urandom_range(0, 1);
         dec_rd        = RW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
         dec_rs1       = RW'($urandom_range(0, 7));
         dec_rs2       = RW'($urandom_range(0, 31));
         rob_tail_id   = RSW'($urandom);
         rob_rf_enable = $urandom_range(0, 1);
         rd            = $urandom_range(0, 1) ? int'(dec_rs1) : $urandom_range(0, 7);
         rob_rf_rd     = RW'(rd);
         rob_rf_val    = $urandom;
         if (m_dep[rd] >= 0 && $urandom_range(0, 2) != 0)
            rob_head_id = RSW'((m_dep[rd] + 1) % ROB_SIZE);
         else
            rob_head_id = RSW'($urandom);
         cycle("random", 1);
      end

      idle();
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file.md
# register_file

Architectural register file with rename tags for the out-of-order core. It holds x0–x31 and, per register, the ROB entry that will produce its next value. It serves the decoder's two source lookups combinationally and takes rename writes from dispatch. It retires commits from the reorder buffer's `rob_rf_*` commit port and discards all rename state on flush.

## Interface
Parameters (global macros from `global_params.v`):
- `XLEN`, 32: register width.
- `REG_CNT_WIDTH`, 5: register index width (32 registers).
- `ROB_SIZE_WIDTH`, from `global_params.v`: ROB index width.
- `DEPENDENCY_WIDTH`, `ROB_SIZE_WIDTH`+1: dependency tag width.
  - All-ones means "no dependency, value in RF".
  - Otherwise the low `ROB_SIZE_WIDTH` bits are the ROB id.

Ports:
- `clk` input 1: clock; single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `rdy` input 1: global enable; when low, all state holds.
- `flush` input 1: mispredict flush (driven by `rob_flush`).
- `stall` input 1: dispatch stall; blocks rename.
- `dec_ready` input 1: decoder presents a valid instruction.
- `dec_rs1`, `dec_rs2` input `REG_CNT_WIDTH`: source registers.
- `dec_rd` input `REG_CNT_WIDTH`: destination; decoder drives 0 for branches and stores.
- `rob_tail_id` input `ROB_SIZE_WIDTH`: ROB id allocated to the dispatching instruction.
- `rob_head_id` input `ROB_SIZE_WIDTH`: current ROB head.
- `rob_rf_enable` input 1: commit write valid.
- `rob_rf_rd` input `REG_CNT_WIDTH`: commit destination.
- `rob_rf_val` input `XLEN`: commit value.
- `rf_dep1`, `rf_dep2` output `DEPENDENCY_WIDTH`: tag for rs1 / rs2, combinational.
- `rf_val1`, `rf_val2` output `XLEN`: value for rs1 / rs2, combinational; meaningful only when the corresponding dep is all-ones.

## Operation
- State:
  - `regs[32]`, each `XLEN` wide.
  - `dep[32]`, each `DEPENDENCY_WIDTH` wide.
- Commit id:
  - `commit_id = rob_head_id - 1`, modulo 2^`ROB_SIZE_WIDTH`.
  - Rationale: the ROB advances its head on the same edge that registers `rob_rf_*`.
  - Wrap-around: head 0 gives commit_id = `ROB_SIZE`-1.
- Commit, when `rob_rf_enable` and `rob_rf_rd` != 0:
  - Always write `regs[rob_rf_rd] <= rob_rf_val`.
  - Set `dep[rob_rf_rd]` to all-ones only if `dep[rob_rf_rd] == {1'b0, commit_id}`.
  - A later rename of the same register is preserved.
- Rename, when `dec_ready && !stall && !flush && dec_rd != 0`:
  - `dep[dec_rd] <= {1'b0, rob_tail_id}`.
- Same-cycle commit and rename to the same rd:
  - The value write happens.
  - Rename wins on `dep`.
- Flush:
  - All 32 `dep` entries go to all-ones.
  - Rename is ignored.
  - A commit write in the same cycle still updates `regs` (JALR commits and flushes together).
- x0: never renamed, never written; reads always return dep all-ones, val 0.
- Read port *k* (rs = `dec_rsk`):
  - If rs == 0: dep all-ones, val 0.
  - Else, if `rob_rf_enable && rob_rf_rd == rs && dep[rs] == {1'b0, commit_id}`: dep all-ones, val = `rob_rf_val` (commit bypass).
  - Else: dep = `dep[rs]`, val = `regs[rs]`.
  - Reads never see the rename of the instruction being dispatched; `rs == rd` in one instruction yields the older tag.
- `rdy` low: no state change; outputs remain combinational from held state.

## Timing
- Reset, on the first rising edge with `rst` high:
  - All `regs` = 0.
  - All `dep` = all-ones.
  - Hence every read output is dep all-ones, val 0.
- Read latency: 0 cycles, combinational from `dec_rs*`, state and commit inputs.
- Rename visible on the cycle after the edge.
- Commit value is visible in the same cycle via the bypass, and from state afterwards.
- `rst` has priority over `rdy` and `flush`.
- `flush` has priority over rename, not over commit value write.
- Reset asserted mid-operation discards all renames and values on that edge.

## Test plan
- Reset:
  - Stimulus: `rst` 1 cycle, then read rs1=5, rs2=0.
  - Required: both deps all-ones, both vals 0.
- Rename then commit with bypass:
  - Stimulus: dispatch rd=3 with tail=4. Next cycle read rs1=3. Later drive `rob_rf_enable`=1, rd=3, val=0xDEADBEEF, head=5.
  - Required: the read returns dep=4. In the commit cycle, rs1=3 returns dep all-ones, val 0xDEADBEEF. The following cycle still returns 0xDEADBEEF.
- Stale commit:
  - Stimulus: rd=7 renamed to ROB 2, then renamed to ROB 6. Commit rd=7 with head=3, val=0x11.
  - Required: `regs[7]`=0x11 and dep[7] stays 6.
- Same-cycle rename and commit:
  - Stimulus: dep[9]=1. Commit rd=9 (head=2) while dispatching rd=9 with tail=7.
  - Required: dep[9]=7 next cycle.
- Flush with commit:
  - Stimulus: deps set on x1, x2, x31. Assert `flush` with commit rd=1, val=0x80 and a concurrent rename of rd=4.
  - Required: next cycle all deps all-ones, `regs[1]`=0x80, x4 not renamed.
- Wrap-around and x0:
  - Stimulus: commit with head=0 for a register tagged `ROB_SIZE`-1. Separately dispatch/commit rd=0.
  - Required: the tag clears. x0 stays val 0, dep all-ones.
